// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 pixel capture path.
package ov7670_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_CFG   = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_ACTIVE     = 2'd2
  } cap_state_e;

  localparam int RGB565_W = 16;
  localparam int R_MSB    = 15;
  localparam int R_LSB    = 11;
  localparam int G_MSB    = 10;
  localparam int G_LSB    = 5;
  localparam int B_MSB    = 4;
  localparam int B_LSB    = 0;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // The sensor sends R/G-high first, so the first byte is the pixel MSB.
  function automatic logic [RGB565_W-1:0] pack_rgb565(input logic [7:0] hi_b,
                                                      input logic [7:0] lo_b);
    return {hi_b, lo_b};
  endfunction

endpackage

// File: rtl/ov7670_byte_pair.sv
// Pairs consecutive HREF-high bytes into one RGB565 pixel; phase restarts whenever HREF drops.
module ov7670_byte_pair
  import ov7670_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                href_i,
  input  logic [7:0]          d_i,
  output logic                phase_o,
  output logic                pix_valid_o,
  output logic [RGB565_W-1:0] pixel_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  always_comb begin
    phase_d = 1'b0;
    hi_d    = hi_q;
    if (en_i && href_i) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= 8'd0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign phase_o     = phase_q;
  assign pix_valid_o = en_i & href_i & phase_q;
  assign pixel_o     = pack_rgb565(hi_q, d_i);

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 capture: VSYNC/HREF framing, RGB565 pixel writes with linear addresses.
// Optional 2x2 decimation when OV7670_CAPTURE_DECIMATE_EN is defined.
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                config_finished,
  input  logic                vsync,
  input  logic                href,
  input  logic [7:0]          d,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [RGB565_W-1:0] dout,
  output logic                frame_done,
  output logic [7:0]          frame_count,
  output logic                line_err,
  output logic                overflow
);

`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam bit DECIMATE = 1'b1;
  localparam int LIMIT    = (H_ACTIVE / 2) * (V_ACTIVE / 2);
`else
  localparam bit DECIMATE = 1'b0;
  localparam int LIMIT    = H_ACTIVE * V_ACTIVE;
`endif

  // One spare bit so the counter can reach LIMIT even when LIMIT == 2**ADDR_W.
  localparam int CW = ADDR_W + 1;
  localparam int XW = $clog2(H_ACTIVE + 1) + 1;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
  localparam logic [XW-1:0] H_C     = XW'(H_ACTIVE);

  cap_state_e          state_q;
  logic                vsync_q, href_q;
  logic [XW-1:0]       x_q;
  logic                y_odd_q;
  logic [CW-1:0]       cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [RGB565_W-1:0] dout_q;
  logic                frame_done_q;
  logic [7:0]          frame_count_q;
  logic                line_err_q;
  logic                overflow_q;

  logic                bp_en, phase, pix_valid, keep_pix;
  logic [RGB565_W-1:0] pixel;
  logic                vsync_fall, vsync_rise, href_fall;

  assign bp_en      = (state_q == ST_ACTIVE) && config_finished;
  assign vsync_fall = vsync_q & ~vsync;
  assign vsync_rise = ~vsync_q & vsync;
  assign href_fall  = href_q & ~href;
  assign keep_pix   = DECIMATE ? (~x_q[0] & ~y_odd_q) : 1'b1;

  ov7670_byte_pair u_byte_pair (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (bp_en),
    .href_i      (href),
    .d_i         (d),
    .phase_o     (phase),
    .pix_valid_o (pix_valid),
    .pixel_o     (pixel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_CFG;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      x_q           <= '0;
      y_odd_q       <= 1'b0;
      cnt_q         <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      dout_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 8'd0;
      line_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      if (!config_finished) begin
        state_q <= ST_WAIT_CFG;
      end else begin
        case (state_q)
          ST_WAIT_CFG: state_q <= ST_WAIT_FRAME;
          ST_WAIT_FRAME: begin
            if (vsync_fall) begin
              state_q    <= ST_ACTIVE;
              cnt_q      <= '0;
              x_q        <= '0;
              y_odd_q    <= 1'b0;
              line_err_q <= 1'b0;
              overflow_q <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (pix_valid) begin
              // x saturates so an overlong line can never wrap back to H_ACTIVE.
              if (x_q != '1) x_q <= x_q + XW'(1);
              if (keep_pix) begin
                if (cnt_q == LIMIT_C) begin
                  overflow_q <= 1'b1;
                end else begin
                  we_q   <= 1'b1;
                  addr_q <= cnt_q[ADDR_W-1:0];
                  dout_q <= pixel;
                  cnt_q  <= cnt_q + CW'(1);
                end
              end
            end
            if (href_fall) begin
              if ((x_q != H_C) || phase) line_err_q <= 1'b1;
              x_q     <= '0;
              y_odd_q <= ~y_odd_q;
            end
            if (vsync_rise) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
              state_q       <= ST_WAIT_FRAME;
            end
          end
          default: state_q <= ST_WAIT_CFG;
        endcase
      end
    end
  end

  assign we          = we_q;
  assign addr        = addr_q;
  assign dout        = dout_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign line_err    = line_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized frame bench for ov7670_capture with a frame-level scoreboard.
module tb_ov7670_capture;

  localparam int H  = 4;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int V   = 4;
  localparam bit DEC = 1'b1;
  localparam int LIMIT = (H / 2) * (V / 2);
`else
  localparam int V   = 2;
  localparam bit DEC = 1'b0;
  localparam int LIMIT = H * V;
`endif
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, config_finished, vsync, href;
  logic [7:0]    d;
  logic          we, frame_done, line_err, overflow;
  logic [AW-1:0] addr;
  logic [15:0]   dout;
  logic [7:0]    frame_count;

  always #5 clk = ~clk;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .config_finished (config_finished),
    .vsync           (vsync),
    .href            (href),
    .d               (d),
    .we              (we),
    .addr            (addr),
    .dout            (dout),
    .frame_done      (frame_done),
    .frame_count     (frame_count),
    .line_err        (line_err),
    .overflow        (overflow)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  exp_cnt = 0;
  int  exp_fc = 0;
  bit  exp_le = 1'b0;
  bit  exp_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int expv);
    n_chk++;
    if (got == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_cycle", cyc, mon_e.cyc);
        check("wr_addr", int'(addr), mon_e.addr);
        check("wr_dout", int'(dout), mon_e.data);
      end
    end
  end

  // One frame: vsync blank, nlines lines, vsync rise. Model predicts every write.
  task automatic run_frame(input int nlines, input int bad_line, input int bad_len,
                           input bit cap, input bit seq, input int cfg_line,
                           input int drop_byte);
    int         len;
    int         px;
    int         bcount;
    bit         live;
    logic [7:0] hi;
    logic [7:0] b;
    bcount = 0;
    hi     = 8'd0;
    vsync  = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    tick();
    live = cap;
    if (cap) begin
      exp_cnt = 0;
      exp_le  = 1'b0;
      exp_ov  = 1'b0;
      check("line_err_clr", int'(line_err), 0);
      check("overflow_clr", int'(overflow), 0);
    end
    tick();
    for (int y = 0; y < nlines; y++) begin
      if (y == cfg_line) config_finished = 1'b1;
      len = (y == bad_line) ? bad_len : 2 * H;
      for (int i = 0; i < len; i++) begin
        if (seq) begin
          b = 8'(bcount);
          bcount++;
        end else begin
          b = 8'($urandom);
        end
        d    = b;
        href = 1'b1;
        if (y == 0 && i == drop_byte) begin
          config_finished = 1'b0;
          live = 1'b0;
        end
        if (i % 2 == 0) begin
          hi = b;
        end else if (live) begin
          px = i / 2;
          if (!DEC || (px % 2 == 0 && y % 2 == 0)) begin
            if (exp_cnt == LIMIT) exp_ov = 1'b1;
            else begin
              exp_q.push_back('{cyc + 1, exp_cnt, int'({hi, b})});
              exp_cnt++;
            end
          end
        end
        tick();
      end
      href = 1'b0;
      d    = 8'($urandom);
      tick();
      if (live && len != 2 * H) exp_le = 1'b1;
      repeat (2) tick();
      if (live) check("line_err_mid", int'(line_err), int'(exp_le));
    end
    vsync = 1'b1;
    tick();
    if (live) exp_fc = (exp_fc + 1) % 256;
    check("frame_done", int'(frame_done), int'(live));
    tick();
    check("frame_done_pulse", int'(frame_done), 0);
    check("frame_count", int'(frame_count), exp_fc);
    check("q_empty", exp_q.size(), 0);
    if (live) begin
      check("line_err_end", int'(line_err), int'(exp_le));
      check("overflow_end", int'(overflow), int'(exp_ov));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, int'(we), 0);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_dout"}, int'(dout), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
    check({tag, "_line_err"}, int'(line_err), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    config_finished = 1'b0;
    vsync = 1'b1;
    href = 1'b0;
    d = 8'd0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_frame(V, -1, 0, 1'b0, 1'b0, -1, -1);   // configuration not finished
    run_frame(V, -1, 0, 1'b0, 1'b0, 1, -1);    // config rises mid-frame: skipped
    run_frame(V, -1, 0, 1'b1, 1'b1, -1, -1);   // sequential bytes 0x00..
    repeat (3) run_frame(V, -1, 0, 1'b1, 1'b0, -1, -1);
    run_frame(V, 0, 7, 1'b1, 1'b0, -1, -1);    // odd-length first line
    run_frame(V, -1, 0, 1'b1, 1'b0, -1, -1);   // clean frame clears line_err
    run_frame(V + 1, -1, 0, 1'b1, 1'b0, -1, -1); // extra line overflows
    run_frame(V, -1, 0, 1'b1, 1'b0, -1, 5);    // config drops on a second byte
    config_finished = 1'b1;
    run_frame(V, -1, 0, 1'b1, 1'b1, -1, -1);   // recovery after config drop

    // Asynchronous reset in the middle of an active line.
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    href = 1'b1;
    d = 8'hA5;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    href = 1'b0;
    exp_fc = 0;
    tick();
    run_frame(V, -1, 0, 1'b1, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
